mul20_seq: RTL and testbench

Sequential unsigned 20x20 -> 40-bit shift-and-add multiplier for the 20-bit datapath ALU.
- Consumes one add20 ripple adder result per cycle and processes one multiplier bit per cycle.
- Sits between the operand/register-read stage and ALU writeback.
- Uses a valid/ready handshake on both sides.

---
 rtl/mul20_seq_pkg.sv | 6 +
 rtl/mul20_seq_if.sv | 15 +
 rtl/mul20_seq_add20.sv | 12 +
 rtl/mul20_seq.sv | 68 ++++++
 tb/tb_mul20_seq.sv | 136 +++++++++++++
 5 files changed

// File: rtl/mul20_seq_pkg.sv
// mul20_seq_pkg: shared ALU constants and multiplier state encoding.
package mul20_seq_pkg;
    localparam int DATA_W = 20;
    localparam int PROD_W = 2 * DATA_W;
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_e;
endpackage

// File: rtl/mul20_seq_if.sv
// mul20_seq_if: operand/product valid-ready bus of the sequential multiplier.
interface mul20_seq_if;
    import mul20_seq_pkg::*;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] prod_hi;
    logic [DATA_W-1:0] prod_lo;
    logic              ovf;
    modport master (output in_valid, a, b, out_ready, input in_ready, out_valid, prod_hi, prod_lo, ovf);
    modport slave  (input in_valid, a, b, out_ready, output in_ready, out_valid, prod_hi, prod_lo, ovf);
endinterface

// File: rtl/mul20_seq_add20.sv
// mul20_seq_add20: 20-bit adder with carry-in tied low and carry out exposed.
module mul20_seq_add20
    import mul20_seq_pkg::*;
(
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    output logic [DATA_W-1:0] sum_o,
    output logic              cout_o
);
    localparam logic CIN = 1'b0;
    assign {cout_o, sum_o} = {1'b0, a_i} + {1'b0, b_i} + {{DATA_W{1'b0}}, CIN};
endmodule

// File: rtl/mul20_seq.sv
// mul20_seq: unsigned 20x20->40 shift-and-add multiplier, one multiplier bit per cycle.
module mul20_seq
    import mul20_seq_pkg::*;
#(
    parameter int WIDTH = DATA_W,
    parameter int CNT_W = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    mul20_seq_if.slave  bus
);
    state_e             state_q, state_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   sum;
    logic               cout;

    mul20_seq_add20 u_add (.a_i(hi_q), .b_i(mcand_q), .sum_o(sum), .cout_o(cout));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            mcand_q <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            mcand_q <= mcand_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        mcand_d = mcand_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: if (bus.in_valid) begin
                mcand_d = bus.a;
                lo_d    = bus.b;
                hi_d    = '0;
                cnt_d   = '0;
                state_d = RUN;
            end
            // adder carry lands in hi's MSB as the pair shifts right
            RUN: begin
                {hi_d, lo_d} = lo_q[0] ? {cout, sum, lo_q[WIDTH-1:1]} : {1'b0, hi_q, lo_q[WIDTH-1:1]};
                cnt_d        = cnt_q + 1'b1;
                state_d      = (cnt_q == CNT_W'(WIDTH - 1)) ? DONE : RUN;
            end
            DONE:    state_d = bus.out_ready ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.prod_hi   = bus.out_valid ? hi_q : '0;
    assign bus.prod_lo   = bus.out_valid ? lo_q : '0;
    assign bus.ovf       = bus.out_valid & (|hi_q);
endmodule

// File: tb/tb_mul20_seq.sv
// tb_mul20_seq: randomized self-checking bench for mul20_seq against an arithmetic product model.
module tb_mul20_seq;
    import mul20_seq_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    mul20_seq_if bus ();
    mul20_seq dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.a = '0; bus.b = '0;
        #3;
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.prod_hi !== '0 || bus.prod_lo !== '0 || bus.ovf !== 1'b0)
            begin failures++; $display("FAIL reset_hold: rdy=%b vld=%b hi=%h lo=%h ovf=%b, want 1 0 0 0 0", bus.in_ready, bus.out_valid, bus.prod_hi, bus.prod_lo, bus.ovf); end
        tick; tick;
        rst_n = 1'b1;
        tick;
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.prod_lo !== '0)
            begin failures++; $display("FAIL reset_release: rdy=%b vld=%b lo=%h, want 1 0 0", bus.in_ready, bus.out_valid, bus.prod_lo); end
    endtask

    task automatic do_mul(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b, input int hold, input string tag);
        logic [PROD_W-1:0] exp;
        logic [PROD_W-1:0] got;
        int lat;
        exp = {{DATA_W{1'b0}}, a} * {{DATA_W{1'b0}}, b};
        lat = 0;
        bus.a = a; bus.b = b; bus.in_valid = 1'b1; bus.out_ready = (hold == 0);
        tick;
        bus.in_valid = 1'b0; bus.a = DATA_W'($urandom); bus.b = DATA_W'($urandom);
        while (!bus.out_valid && lat < 40) begin tick; lat++; end
        checks++;
        if (lat != 20) begin failures++; $display("FAIL %s latency: got %0d want 20", tag, lat); end
        got = {bus.prod_hi, bus.prod_lo};
        checks++;
        if (got !== exp) begin failures++; $display("FAIL %s product: got %h want %h", tag, got, exp); end
        checks++;
        if (bus.ovf !== (|exp[PROD_W-1:DATA_W])) begin failures++; $display("FAIL %s ovf: got %b want %b", tag, bus.ovf, |exp[PROD_W-1:DATA_W]); end
        for (int i = 0; i < hold; i++) begin
            bus.in_valid = 1'b1; bus.a = DATA_W'($urandom); bus.b = DATA_W'($urandom);
            tick;
            checks++;
            if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || {bus.prod_hi, bus.prod_lo} !== exp)
                begin failures++; $display("FAIL %s hold%0d: vld=%b rdy=%b prod=%h want 1 0 %h", tag, i, bus.out_valid, bus.in_ready, {bus.prod_hi, bus.prod_lo}, exp); end
        end
        bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        tick;
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.prod_hi !== '0 || bus.prod_lo !== '0)
            begin failures++; $display("FAIL %s to_idle: rdy=%b vld=%b hi=%h lo=%h want 1 0 0 0", tag, bus.in_ready, bus.out_valid, bus.prod_hi, bus.prod_lo); end
    endtask

    task automatic test_basic;
        do_mul(20'd3, 20'd5, 0, "3x5");
        do_mul(20'hFFFFF, 20'hFFFFF, 0, "max");
        do_mul(20'h80000, 20'h00002, 0, "msb");
        do_mul(20'h00000, 20'h12345, 0, "zero");
        for (int i = 0; i < 3; i++) do_mul(DATA_W'($urandom), DATA_W'($urandom), 0, "rand");
    endtask

    task automatic test_backpressure;
        do_mul(DATA_W'($urandom), DATA_W'($urandom), 10, "bp");
        do_mul(20'h0ABCD, 20'h00123, 0, "after_bp");
    endtask

    task automatic test_reset_mid_run;
        int seen;
        seen = 0;
        bus.a = DATA_W'($urandom); bus.b = DATA_W'($urandom); bus.in_valid = 1'b1; bus.out_ready = 1'b1;
        tick;
        bus.in_valid = 1'b0;
        for (int i = 0; i < 7; i++) tick;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.prod_hi !== '0 || bus.prod_lo !== '0 || bus.ovf !== 1'b0)
            begin failures++; $display("FAIL midrun_reset: rdy=%b vld=%b hi=%h lo=%h ovf=%b want 1 0 0 0 0", bus.in_ready, bus.out_valid, bus.prod_hi, bus.prod_lo, bus.ovf); end
        tick; tick;
        rst_n = 1'b1;
        for (int i = 0; i < 25; i++) begin tick; if (bus.out_valid) seen++; end
        checks++;
        if (seen != 0) begin failures++; $display("FAIL midrun_no_valid: got %0d valid cycles want 0", seen); end
        do_mul(20'd7, 20'd6, 0, "7x6");
    endtask

    task automatic test_back_to_back;
        logic [DATA_W-1:0] qa [4];
        logic [DATA_W-1:0] qb [4];
        logic [PROD_W-1:0] exp;
        int k, cyc, last;
        k = 0; cyc = 0; last = -1;
        for (int i = 0; i < 4; i++) begin qa[i] = DATA_W'($urandom); qb[i] = DATA_W'($urandom); end
        bus.a = qa[0]; bus.b = qb[0]; bus.in_valid = 1'b1; bus.out_ready = 1'b1;
        while (k < 4 && cyc < 200) begin
            tick; cyc++;
            if (bus.out_valid) begin
                exp = {{DATA_W{1'b0}}, qa[k]} * {{DATA_W{1'b0}}, qb[k]};
                checks++;
                if ({bus.prod_hi, bus.prod_lo} !== exp) begin failures++; $display("FAIL b2b%0d product: got %h want %h", k, {bus.prod_hi, bus.prod_lo}, exp); end
                if (last >= 0) begin
                    checks++;
                    if (cyc - last != 22) begin failures++; $display("FAIL b2b%0d interval: got %0d want 22", k, cyc - last); end
                end
                last = cyc;
                k++;
                if (k < 4) begin bus.a = qa[k]; bus.b = qb[k]; end
                else bus.in_valid = 1'b0;
            end
        end
        checks++;
        if (k != 4) begin failures++; $display("FAIL b2b_count: got %0d results want 4", k); end
        tick;
    endtask

    initial begin
        test_reset;
        test_basic;
        test_backpressure;
        test_reset_mid_run;
        test_back_to_back;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
